stall_flush_ctrl: RTL and testbench
===================================

// Module: stall_flush_ctrl
// PURPOSE
//  Consumer side of the hazard interface: turns the hazard unit's stall request into IF/ID/EX pipeline controls.
//  - Freezes PC and IF/ID, inserts an ID/EX bubble, flushes IF/ID on a taken branch or jump.
//  - Drains the pipeline after HALT is decoded, then parks.
//  - Keeps a stall watchdog and saturating performance counters for the debug unit.
//  Sits between the hazard unit/ID stage and the PC, IF/ID and ID/EX register write enables.
// PARAMETERS
//  NB_CNT        32  width of the performance counters
//  MAX_STALL     2   maximum consecutive stalled valid cycles before the watchdog fires
//  DRAIN_CYCLES  3   valid cycles after HALT decode before parking (ID->EX->MEM->WB)
// PORTS
//  i_clock        in   1       system clock, all state on posedge
//  i_reset        in   1       asynchronous, active-high reset
//  i_valid        in   1       pipeline advance enable (debug step/run); 0 freezes everything
//  i_hazard       in   1       stall request from hazard unit, same cycle
//  i_branch_taken in   1       branch or jump resolved taken in ID
//  i_halt_id      in   1       HALT instruction present in ID
//  o_pc_we        out  1       PC write enable
//  o_ifid_we      out  1       IF/ID write enable
//  o_ifid_flush   out  1       load NOP into IF/ID
//  o_idex_bubble  out  1       load NOP into ID/EX
//  o_halted       out  1       pipeline parked after drain
//  o_wdog_err     out  1       sticky: stall exceeded MAX_STALL
//  o_stall_cnt    out  NB_CNT  stalled valid cycles
//  o_flush_cnt    out  NB_CNT  flushed valid cycles (branch flushes only)
//  o_cycle_cnt    out  NB_CNT  valid cycles spent in RUN or DRAIN
// BEHAVIOUR
//  Reset (async, immediate):
//  - state=RUN; stall_run=0; drain_cnt=0; all counters=0; o_wdog_err=0; o_halted=0.
//  - While i_reset=1, o_pc_we, o_ifid_we, o_ifid_flush and o_idex_bubble are forced to 0.
//  Control outputs: combinational from state, registered counters and inputs (0-cycle latency).
//  Registered state advances only on posedge with i_valid=1.
//  i_valid=0: all four controls 0; state, counters and stall_run hold.
//  FSM states: RUN, DRAIN, HALTED.
//  RUN (i_valid=1), priority order: hazard > halt > branch.
//  - Hazard stall: i_hazard=1 and stall_run<MAX_STALL.
//    - pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0.
//    - stall_run++, stall_cnt++.
//  - Watchdog: i_hazard=1 and stall_run==MAX_STALL.
//    - Hazard is ignored and the pipeline advances (treated as no hazard).
//    - o_wdog_err<=1 (sticky until reset); stall_run<=0.
//  - Halt: i_hazard=0 (or ignored) and i_halt_id=1.
//    - pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=0.
//    - drain_cnt<=DRAIN_CYCLES; state<=DRAIN. A simultaneous i_branch_taken is ignored.
//  - Branch: i_branch_taken=1 and no stall/halt.
//    - pc_we=1, ifid_we=1, ifid_flush=1.
//    - flush_cnt++, stall_run<=0.
//  - Otherwise: pc_we=1, ifid_we=1, flush=0, bubble=0; stall_run<=0.
//  - cycle_cnt++ on every valid cycle in RUN and DRAIN.
//  DRAIN (i_valid=1):
//  - pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=0.
//  - Inputs are ignored.
//  - drain_cnt--; when drain_cnt==1 at the edge, state<=HALTED.
//  HALTED:
//  - All controls 0; o_halted=1 (registered, from state).
//  - No counters change; exit only via reset.
//  Counters:
//  - Saturate at {NB_CNT{1'b1}}, no wrap.
//  - stall_cnt counts hazard-stall cycles only, not drain or watchdog-override cycles.
//  Reset mid-operation (during a stall or DRAIN): returns to RUN immediately; next valid cycle is a normal advance.
// TESTING
//  - Reset, i_valid=1, no requests: pc_we=ifid_we=1, flush=bubble=0; after 10 cycles cycle_cnt=10, stall_cnt=0.
//  - i_hazard=1 for 1 cycle: that cycle pc_we=0, ifid_we=0, idex_bubble=1; next cycle normal; stall_cnt=1.
//  - i_hazard and i_branch_taken both 1: stall only (flush=0, flush_cnt=0).
//    Next cycle branch alone: ifid_flush=1, pc_we=1, flush_cnt=1.
//  - i_hazard held high, MAX_STALL=2: cycles 1-2 stall; cycle 3 pc_we=1, bubble=0.
//    o_wdog_err=1 from cycle 4 and stays 1; stall_cnt=2.
//  - i_halt_id pulse: 4 cycles with ifid_flush=1 and pc_we=0; o_halted=1 on cycle 5.
//    Further i_branch_taken/i_hazard produce no enables; cycle_cnt frozen at halt-entry+4.
//  - i_valid=0 mid-stall holds stall_run. Async reset in DRAIN:
//    state RUN and counters 0 without a clock edge; o_halted never asserts.

Source files
------------

// File: rtl/stall_flush_ctrl.sv
// Stall/flush controller: turns hazard-unit stall requests, taken branches and HALT decode
// into PC, IF/ID and ID/EX write controls, with a stall watchdog and saturating counters.
module stall_flush_ctrl #(
  parameter int NB_CNT       = 32,
  parameter int MAX_STALL    = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_hazard,
  input  logic              i_branch_taken,
  input  logic              i_halt_id,
  output logic              o_pc_we,
  output logic              o_ifid_we,
  output logic              o_ifid_flush,
  output logic              o_idex_bubble,
  output logic              o_halted,
  output logic              o_wdog_err,
  output logic [NB_CNT-1:0] o_stall_cnt,
  output logic [NB_CNT-1:0] o_flush_cnt,
  output logic [NB_CNT-1:0] o_cycle_cnt
);

  localparam int RUN_W   = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [RUN_W-1:0]   MAX_RUN   = RUN_W'(MAX_STALL);
  localparam logic [DRAIN_W-1:0] DRAIN_LD  = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [RUN_W-1:0]   stall_run;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               hazard_stall;
  logic               wdog_fire;
  logic               halt_take;
  logic               branch_take;

  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
    return (&v) ? v : v + NB_CNT'(1);
  endfunction

  // Request decode: a watchdog-overridden hazard falls through to halt/branch/advance.
  always_comb begin
    hazard_stall = (state == RUN) && i_hazard && (stall_run < MAX_RUN);
    wdog_fire    = (state == RUN) && i_hazard && (stall_run >= MAX_RUN);
    halt_take    = (state == RUN) && !hazard_stall && i_halt_id;
    branch_take  = (state == RUN) && !hazard_stall && !i_halt_id && i_branch_taken;
  end

  always_comb begin
    state_next    = state;
    o_pc_we       = 1'b0;
    o_ifid_we     = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    if (i_valid) begin
      case (state)
        RUN: if (halt_take) state_next = DRAIN;
        DRAIN: if (drain_cnt == DRAIN_END) state_next = HALTED;
        default: state_next = state;
      endcase
    end
    if (i_valid && !i_reset) begin
      case (state)
        RUN: begin
          if (hazard_stall) begin
            o_idex_bubble = 1'b1;
          end else if (halt_take) begin
            o_ifid_flush = 1'b1;
          end else begin
            o_pc_we      = 1'b1;
            o_ifid_we    = 1'b1;
            o_ifid_flush = branch_take;
          end
        end
        DRAIN:   o_ifid_flush = 1'b1;
        default: o_ifid_flush = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= RUN;
      stall_run <= '0;
      drain_cnt <= '0;
    end else if (i_valid) begin
      state <= state_next;
      if (state == RUN) begin
        stall_run <= hazard_stall ? stall_run + RUN_W'(1) : '0;
        if (halt_take) drain_cnt <= DRAIN_LD;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt - DRAIN_W'(1);
      end
    end
  end

  // Debug-visible status and saturating counters.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_wdog_err  <= 1'b0;
      o_halted    <= 1'b0;
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
      o_cycle_cnt <= '0;
    end else if (i_valid) begin
      o_halted <= (state_next == HALTED);
      if (wdog_fire) o_wdog_err <= 1'b1;
      if (hazard_stall) o_stall_cnt <= sat_inc(o_stall_cnt);
      if (branch_take) o_flush_cnt <= sat_inc(o_flush_cnt);
      if (state != HALTED) o_cycle_cnt <= sat_inc(o_cycle_cnt);
    end
  end

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Bench for stall_flush_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_stall_flush_ctrl;

  localparam int NB   = 6;
  localparam int MS   = 2;
  localparam int DC   = 3;
  localparam int CMAX = (1 << NB) - 1;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_hazard = 1'b0;
  logic          i_branch_taken = 1'b0;
  logic          i_halt_id = 1'b0;
  logic          o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble, o_halted, o_wdog_err;
  logic [NB-1:0] o_stall_cnt, o_flush_cnt, o_cycle_cnt;

  int checks = 0;
  int errors = 0;

  stall_flush_ctrl #(.NB_CNT(NB), .MAX_STALL(MS), .DRAIN_CYCLES(DC)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_hazard(i_hazard),
    .i_branch_taken(i_branch_taken), .i_halt_id(i_halt_id),
    .o_pc_we(o_pc_we), .o_ifid_we(o_ifid_we), .o_ifid_flush(o_ifid_flush),
    .o_idex_bubble(o_idex_bubble), .o_halted(o_halted), .o_wdog_err(o_wdog_err),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt), .o_cycle_cnt(o_cycle_cnt)
  );

  always #5 i_clock = ~i_clock;

  // Reference model: mode 0 running, 1 draining (m_left cycles remain), 2 parked.
  int       m_mode, m_run, m_left, m_stall, m_flush, m_cycle;
  bit       m_wdog;
  logic [3:0] e_ctrl;

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_run = 0; m_left = 0; m_stall = 0; m_flush = 0; m_cycle = 0; m_wdog = 0;
  endfunction

  // Expected {pc_we, ifid_we, ifid_flush, idex_bubble} for the current inputs.
  function automatic void model_comb();
    e_ctrl = 4'b0000;
    if (i_reset || !i_valid) return;
    if (m_mode == 1) e_ctrl = 4'b0010;
    else if (m_mode == 0) begin
      if (i_hazard && m_run < MS) e_ctrl = 4'b0001;
      else if (i_halt_id)         e_ctrl = 4'b0010;
      else if (i_branch_taken)    e_ctrl = 4'b1110;
      else                        e_ctrl = 4'b1100;
    end
  endfunction

  function automatic void model_seq();
    if (i_reset || !i_valid) return;
    if (m_mode == 0) begin
      m_cycle = sat(m_cycle);
      if (i_hazard && m_run < MS) begin
        m_run++;
        m_stall = sat(m_stall);
      end else begin
        if (i_hazard) m_wdog = 1;
        m_run = 0;
        if (i_halt_id) begin
          m_mode = 1;
          m_left = DC;
        end else if (i_branch_taken) m_flush = sat(m_flush);
      end
    end else if (m_mode == 1) begin
      m_cycle = sat(m_cycle);
      m_left--;
      if (m_left == 0) m_mode = 2;
    end
  endfunction

  task automatic set_in(input bit v, input bit h, input bit b, input bit hl);
    i_valid = v; i_hazard = h; i_branch_taken = b; i_halt_id = hl;
    model_comb();
    #1;
  endtask

  task automatic step();
    @(posedge i_clock);
    model_seq();
    @(negedge i_clock);
  endtask

  task automatic do_reset();
    @(negedge i_clock);
    i_reset = 1'b1;
    i_valid = 0; i_hazard = 0; i_branch_taken = 0; i_halt_id = 0;
    model_reset();
    @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  function automatic logic [3:0] ctrl();
    return {o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble};
  endfunction

  task automatic test_reset();
    model_reset();
    @(negedge i_clock);
    set_in(1, 1, 1, 1);
    checks++;
    if (ctrl() !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", ctrl()); end
    checks++;
    if ({o_halted, o_wdog_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {o_halted, o_wdog_err}); end
    checks++;
    if ({o_stall_cnt, o_flush_cnt, o_cycle_cnt} !== '0) begin
      errors++; $display("FAIL reset_cnt got=%0h/%0h/%0h exp=0", o_stall_cnt, o_flush_cnt, o_cycle_cnt);
    end
    @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  task automatic test_normal();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1, 0, 0, 0);
      checks++;
      if (ctrl() !== 4'b1100) begin errors++; $display("FAIL normal_ctrl c%0d got=%b exp=1100", i, ctrl()); end
      step();
    end
    checks++;
    if (o_cycle_cnt !== NB'(10)) begin errors++; $display("FAIL normal_cycle got=%0d exp=10", o_cycle_cnt); end
    checks++;
    if (o_stall_cnt !== '0) begin errors++; $display("FAIL normal_stall got=%0d exp=0", o_stall_cnt); end
  endtask

  task automatic test_hazard_single();
    do_reset();
    set_in(1, 1, 0, 0);
    checks++;
    if (ctrl() !== 4'b0001) begin errors++; $display("FAIL hz1_stall got=%b exp=0001", ctrl()); end
    step();
    set_in(1, 0, 0, 0);
    checks++;
    if (ctrl() !== 4'b1100) begin errors++; $display("FAIL hz1_resume got=%b exp=1100", ctrl()); end
    step();
    checks++;
    if (o_stall_cnt !== NB'(1)) begin errors++; $display("FAIL hz1_cnt got=%0d exp=1", o_stall_cnt); end
  endtask

  task automatic test_hazard_branch();
    do_reset();
    set_in(1, 1, 1, 0);
    checks++;
    if (ctrl() !== 4'b0001) begin errors++; $display("FAIL hzbr_stall got=%b exp=0001", ctrl()); end
    step();
    checks++;
    if (o_flush_cnt !== '0) begin errors++; $display("FAIL hzbr_fcnt0 got=%0d exp=0", o_flush_cnt); end
    set_in(1, 0, 1, 0);
    checks++;
    if (ctrl() !== 4'b1110) begin errors++; $display("FAIL hzbr_branch got=%b exp=1110", ctrl()); end
    step();
    checks++;
    if (o_flush_cnt !== NB'(1)) begin errors++; $display("FAIL hzbr_fcnt1 got=%0d exp=1", o_flush_cnt); end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 0, 0);
      checks++;
      if (ctrl() !== 4'b0001) begin errors++; $display("FAIL wd_stall c%0d got=%b exp=0001", i, ctrl()); end
      step();
    end
    set_in(1, 1, 0, 0);
    checks++;
    if ({ctrl(), o_wdog_err} !== 5'b11000) begin errors++; $display("FAIL wd_override got=%b exp=11000", {ctrl(), o_wdog_err}); end
    step();
    checks++;
    if (o_stall_cnt !== NB'(2)) begin errors++; $display("FAIL wd_stallcnt got=%0d exp=2", o_stall_cnt); end
    for (int i = 0; i < 4; i++) begin
      set_in(1, i < 2, 0, 0);
      checks++;
      if (o_wdog_err !== 1'b1) begin errors++; $display("FAIL wd_sticky c%0d got=%b exp=1", i, o_wdog_err); end
      step();
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 2; i++) begin set_in(1, 0, 0, 0); step(); end
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, i == 0, i == 0);
      checks++;
      if ({ctrl(), o_halted} !== 5'b00100) begin errors++; $display("FAIL halt_drain c%0d got=%b exp=00100", i, {ctrl(), o_halted}); end
      step();
    end
    checks++;
    if (o_halted !== 1'b1) begin errors++; $display("FAIL halt_parked got=%b exp=1", o_halted); end
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (ctrl() !== 4'b0000) begin errors++; $display("FAIL halt_noen c%0d got=%b exp=0000", i, ctrl()); end
      step();
    end
    checks++;
    if ({o_cycle_cnt, o_stall_cnt, o_flush_cnt} !== {NB'(6), NB'(0), NB'(0)}) begin
      errors++; $display("FAIL halt_frozen got=%0d/%0d/%0d exp=6/0/0", o_cycle_cnt, o_stall_cnt, o_flush_cnt);
    end
  endtask

  task automatic test_valid_hold();
    do_reset();
    set_in(1, 1, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 1, 1);
      checks++;
      if (ctrl() !== 4'b0000) begin errors++; $display("FAIL vhold_ctrl c%0d got=%b exp=0000", i, ctrl()); end
      step();
    end
    checks++;
    if ({o_stall_cnt, o_cycle_cnt} !== {NB'(1), NB'(1)}) begin
      errors++; $display("FAIL vhold_cnt got=%0d/%0d exp=1/1", o_stall_cnt, o_cycle_cnt);
    end
    set_in(1, 1, 0, 0);
    checks++;
    if (ctrl() !== 4'b0001) begin errors++; $display("FAIL vhold_stall2 got=%b exp=0001", ctrl()); end
    step();
    set_in(1, 1, 0, 0);
    checks++;
    if (ctrl() !== 4'b1100) begin errors++; $display("FAIL vhold_wdog got=%b exp=1100", ctrl()); end
    step();
    checks++;
    if ({o_wdog_err, o_stall_cnt} !== {1'b1, NB'(2)}) begin
      errors++; $display("FAIL vhold_end got=%b/%0d exp=1/2", o_wdog_err, o_stall_cnt);
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    set_in(1, 0, 0, 1);
    step();
    set_in(1, 0, 0, 0);
    step();
    #2;
    i_reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({ctrl(), o_halted, o_cycle_cnt} !== {4'b0000, 1'b0, NB'(0)}) begin
      errors++; $display("FAIL rstdrain_async ctrl=%b halted=%b cyc=%0d exp=0000/0/0", ctrl(), o_halted, o_cycle_cnt);
    end
    @(negedge i_clock);
    i_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 0);
      checks++;
      if ({ctrl(), o_halted} !== 5'b11000) begin errors++; $display("FAIL rstdrain_run c%0d got=%b exp=11000", i, {ctrl(), o_halted}); end
      step();
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 100; i++) begin set_in(1, 1, 0, 0); step(); end
    checks++;
    if ({o_stall_cnt, o_cycle_cnt} !== {NB'(CMAX), NB'(CMAX)}) begin
      errors++; $display("FAIL sat_cnt got=%0d/%0d exp=%0d/%0d", o_stall_cnt, o_cycle_cnt, CMAX, CMAX);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      i_reset = ($urandom_range(0, 79) == 0);
      if (i_reset) model_reset();
      set_in($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
      checks++;
      if (ctrl() !== e_ctrl) begin errors++; $display("FAIL rnd_ctrl c%0d got=%b exp=%b", i, ctrl(), e_ctrl); end
      checks++;
      if ({o_halted, o_wdog_err} !== {m_mode == 2, m_wdog}) begin
        errors++; $display("FAIL rnd_flags c%0d got=%b exp=%b", i, {o_halted, o_wdog_err}, {m_mode == 2, m_wdog});
      end
      checks++;
      if ({o_stall_cnt, o_flush_cnt, o_cycle_cnt} !== {NB'(m_stall), NB'(m_flush), NB'(m_cycle)}) begin
        errors++; $display("FAIL rnd_cnt c%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                           o_stall_cnt, o_flush_cnt, o_cycle_cnt, m_stall, m_flush, m_cycle);
      end
      step();
    end
    i_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_hazard_single();
    test_hazard_branch();
    test_watchdog();
    test_halt();
    test_valid_hold();
    test_reset_in_drain();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
